// File: rtl/mio_responder.sv
// Memory/IO bus responder: decodes word requests into RAM, peripheral registers or unmapped
// space, inserts wait states, and signals completion to the CPU through MIO_ready.
module mio_responder #(
  parameter int unsigned RAM_AW   = 10,
  parameter int unsigned RAM_WAIT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] data2CPU,
  output logic        MIO_ready,
  output logic        bus_err,
  input  logic [7:0]  sw_in,
  output logic [7:0]  led_out,
  output logic [31:0] counter_out
);

  localparam int unsigned CntW = (RAM_WAIT > 1) ? $clog2(RAM_WAIT) : 1;
  localparam logic [29:0] LedWaddr = 30'h3C00_0000;  // 0xF0000000 >> 2
  localparam logic [29:0] CntWaddr = 30'h3C00_0001;  // 0xF0000004 >> 2

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;
  typedef enum logic [1:0] {RegRam, RegPeri, RegNone} region_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   wcnt_q, wcnt_d;
  logic [29:0]       addr_q;
  logic              we_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata;
  logic              latch, access;
  region_e           region_q;
  logic [31:0]       mem [2**RAM_AW];
  logic [RAM_AW-1:0] ram_idx;
  logic              unused_addr_lsb;

  // Word address in, region out; only the word bits take part in decoding.
  function automatic region_e decode(input logic [29:0] waddr);
    if (waddr[29:26] == 4'hF) begin
      return RegPeri;
    end else if ((waddr >> RAM_AW) == 30'd0) begin
      return RegRam;
    end else begin
      return RegNone;
    end
  endfunction

  assign unused_addr_lsb = ^mem_addr[1:0];
  assign region_q        = decode(addr_q);
  assign ram_idx         = addr_q[RAM_AW-1:0];

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    latch   = 1'b0;
    access  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (mem_req) begin
          latch   = 1'b1;
          wcnt_d  = (decode(mem_addr[31:2]) == RegRam) ? CntW'(RAM_WAIT - 1) : '0;
          state_d = StBusy;
        end
      end
      StBusy: begin
        if (wcnt_q != '0) begin
          wcnt_d = wcnt_q - 1'b1;
        end else begin
          access  = 1'b1;
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    rdata = 32'd0;
    unique case (region_q)
      RegRam: rdata = mem[ram_idx];
      RegPeri: begin
        if (addr_q == LedWaddr) begin
          rdata = {24'd0, sw_in};
        end else if (addr_q == CntWaddr) begin
          rdata = counter_out;
        end
      end
      default: rdata = 32'd0;
    endcase
  end

  assign MIO_ready = ((state_q == StIdle) && !mem_req) || (state_q == StDone);
  assign bus_err   = (state_q == StDone) && (region_q == RegNone);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      wcnt_q      <= '0;
      addr_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      data2CPU    <= '0;
      led_out     <= '0;
      counter_out <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      if (latch) begin
        addr_q  <= mem_addr[31:2];
        we_q    <= mem_we;
        wdata_q <= mem_wdata;
      end
      if (access && we_q && (region_q == RegPeri) && (addr_q == CntWaddr)) begin
        counter_out <= wdata_q;
      end else begin
        counter_out <= counter_out + 32'd1;
      end
      if (access && we_q && (region_q == RegPeri) && (addr_q == LedWaddr)) begin
        led_out <= wdata_q[7:0];
      end
      if (access && !we_q) begin
        data2CPU <= rdata;
      end
    end
  end

  // RAM is not reset; a reset in the access cycle suppresses the write.
  always_ff @(posedge clk) begin
    if (!reset && access && we_q && (region_q == RegRam)) begin
      mem[ram_idx] <= wdata_q;
    end
  end

endmodule

// File: tb/tb_mio_responder.sv
// Directed self-checking bench for mio_responder with default parameters.
module tb_mio_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] data2CPU;
  logic        MIO_ready;
  logic        bus_err;
  logic [7:0]  sw_in;
  logic [7:0]  led_out;
  logic [31:0] counter_out;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] rd;

  always #5 clk = ~clk;

  mio_responder dut (
    .clk         (clk),
    .reset       (reset),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .data2CPU    (data2CPU),
    .MIO_ready   (MIO_ready),
    .bus_err     (bus_err),
    .sw_in       (sw_in),
    .led_out     (led_out),
    .counter_out (counter_out)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Runs one transaction from IDLE and returns in the DONE cycle with data2CPU sampled.
  task automatic access(input string tag, input logic we, input logic [31:0] a,
                        input logic [31:0] wd, input int lat, input logic err,
                        output logic [31:0] d);
    mem_req   = 1'b1;
    mem_we    = we;
    mem_addr  = a;
    mem_wdata = wd;
    #1;
    check({tag, ":idle_ready"}, 32'(MIO_ready), 32'd0);
    step();
    // Scramble inputs during BUSY; they must be ignored.
    mem_req   = 1'b0;
    mem_we    = ~we;
    mem_addr  = 32'h0000_0FFC;
    mem_wdata = 32'h5555_AAAA;
    for (int i = 0; i < lat; i++) begin
      check({tag, ":busy_ready"}, 32'(MIO_ready), 32'd0);
      check({tag, ":busy_err"}, 32'(bus_err), 32'd0);
      step();
    end
    check({tag, ":done_ready"}, 32'(MIO_ready), 32'd1);
    check({tag, ":done_err"}, 32'(bus_err), 32'(err));
    d = data2CPU;
  endtask

  initial begin
    reset     = 1'b1;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = 32'd0;
    mem_wdata = 32'd0;
    sw_in     = 8'h00;
    step();
    step();
    check("rst_ready", 32'(MIO_ready), 32'd1);
    check("rst_led", 32'(led_out), 32'd0);
    check("rst_cnt", counter_out, 32'd0);
    check("rst_data", data2CPU, 32'd0);
    check("rst_err", 32'(bus_err), 32'd0);
    reset = 1'b0;
    step();
    check("cnt_first_inc", counter_out, 32'd1);

    // Counter read returns the pre-increment value at the access edge.
    access("cnt_rd", 1'b0, 32'hF000_0004, 32'd0, 1, 1'b0, rd);
    check("cnt_rd_data", rd, 32'd2);
    check("cnt_rd_live", counter_out, 32'd3);
    step();

    access("ram_wr", 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 2, 1'b0, rd);
    step();
    access("ram_rd", 1'b0, 32'h0000_0010, 32'd0, 2, 1'b0, rd);
    check("ram_rd_data", rd, 32'hDEAD_BEEF);
    step();
    access("ram_rd13", 1'b0, 32'h0000_0013, 32'd0, 2, 1'b0, rd);
    check("ram_rd13_data", rd, 32'hDEAD_BEEF);
    step();

    sw_in = 8'h3C;
    access("led_wr", 1'b1, 32'hF000_0000, 32'h0000_00A5, 1, 1'b0, rd);
    check("led_val", 32'(led_out), 32'h0000_00A5);
    check("wr_keeps_data", rd, 32'hDEAD_BEEF);
    step();
    access("sw_rd", 1'b0, 32'hF000_0000, 32'd0, 1, 1'b0, rd);
    check("sw_rd_data", rd, 32'h0000_003C);
    step();
    access("peri_other", 1'b0, 32'hF000_0008, 32'd0, 1, 1'b0, rd);
    check("peri_other_data", rd, 32'd0);
    step();

    access("cnt_wr", 1'b1, 32'hF000_0004, 32'hFFFF_FFFE, 1, 1'b0, rd);
    check("cnt_loaded", counter_out, 32'hFFFF_FFFE);
    step();
    check("cnt_max", counter_out, 32'hFFFF_FFFF);
    step();
    check("cnt_wrap", counter_out, 32'h0000_0000);

    access("ram0_wr", 1'b1, 32'h0000_0000, 32'h1111_1111, 2, 1'b0, rd);
    step();
    access("unm_wr", 1'b1, 32'h1000_0000, 32'h0000_0BAD, 1, 1'b1, rd);
    step();
    check("unm_wr_err_clr", 32'(bus_err), 32'd0);
    access("ram0_rd", 1'b0, 32'h0000_0000, 32'd0, 2, 1'b0, rd);
    check("ram0_intact", rd, 32'h1111_1111);
    step();
    access("unm_rd", 1'b0, 32'h1000_0000, 32'd0, 1, 1'b1, rd);
    check("unm_rd_data", rd, 32'd0);
    step();
    check("unm_rd_err_clr", 32'(bus_err), 32'd0);

    // Reset in the middle of a RAM write must drop the write.
    access("ram20_pre", 1'b1, 32'h0000_0020, 32'h0000_0000, 2, 1'b0, rd);
    step();
    mem_req   = 1'b1;
    mem_we    = 1'b1;
    mem_addr  = 32'h0000_0020;
    mem_wdata = 32'h1234_5678;
    step();
    check("abort_busy", 32'(MIO_ready), 32'd0);
    mem_req = 1'b0;
    reset   = 1'b1;
    step();
    reset = 1'b0;
    check("abort_ready", 32'(MIO_ready), 32'd1);
    check("abort_data", data2CPU, 32'd0);
    step();
    access("ram20_rd", 1'b0, 32'h0000_0020, 32'd0, 2, 1'b0, rd);
    check("ram20_not_written", rd, 32'h0000_0000);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
